keypad_scanner: RTL

Scans the calculator's 4x4 matrix keypad, synchronises and debounces the column returns, and emits a single-cycle `keystrobe` with a 4-bit `keycode` per physical key press. Sits directly upstream of the input handler, which splits `keycode` into digit, clear, execute and operator strobes. One strobe per press, no auto-repeat, no multi-key rollover.

---
 rtl/calc_pkg.sv | 58 +++++
 rtl/sync2.sv | 34 +++
 rtl/keypad_scanner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the calculator front end: keycode constants used by
// both the keypad scanner and the input handler, the scanner state encoding,
// and the combinational helpers for turning a row/column hit into a keycode.
package calc_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_EXEC  = 4'hB;
    localparam logic [3:0] KEY_DIV   = 4'hC;
    localparam logic [3:0] KEY_MUL   = 4'hD;
    localparam logic [3:0] KEY_SUB   = 4'hE;
    localparam logic [3:0] KEY_ADD   = 4'hF;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } scan_state_e;

    // Physical key position to keycode. Digits stay below KEY_CLEAR so the
    // input handler can classify with a single compare.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = KEY_ADD;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = KEY_SUB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = KEY_MUL;
            4'b11_00: code = KEY_CLEAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_EXEC;
            default:  code = KEY_DIV;
        endcase
        return code;
    endfunction

    // Returns {hit, index}: hit is set only when exactly one column is low.
    function automatic logic [2:0] col_decode(input logic [3:0] col_n);
        logic [2:0] res;
        case (col_n)
            4'b1110: res = 3'b1_00;
            4'b1101: res = 3'b1_01;
            4'b1011: res = 3'b1_10;
            4'b0111: res = 3'b1_11;
            default: res = 3'b0_00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2
// Two-flop synchroniser for asynchronous inputs, with a caller-supplied
// idle value loaded on reset.
//   clk        system clock
//   reset_n    synchronous active-low reset
//   rst_val_i  value both stages take during reset
//   d_i        asynchronous input
//   q_o        synchronised output (2 cycles latency)
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= rst_val_i;
            sync_q <= rst_val_i;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row at a time, debounces the press
// and the release of a single key, and emits one keystrobe per press.
//   clk        system clock
//   reset_n    synchronous active-low reset
//   col_n      column returns, active-low, asynchronous
//   row_n      row drives, active-low, exactly one low (registered)
//   keystrobe  one-cycle pulse per accepted press
//   keycode    code of the last accepted key, held between strobes
//   key_held   high from the strobe until the release is accepted
//
// state       | meaning
// ST_SCAN     | drive current row for SCAN_CYCLES, then sample columns
// ST_DEBOUNCE | row frozen, latched column must stay stable DEBOUNCE_CYCLES
// ST_RELEASE  | row frozen, all columns must stay high DEBOUNCE_CYCLES
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       keystrobe,
    output logic [3:0] keycode,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    col_s;
    scan_state_e   state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    row_n_q, row_n_d;
    logic [1:0]    col_q, col_d;
    logic [SW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] deb_q, deb_d;
    logic          strobe_q, strobe_d;
    logic [3:0]    code_q, code_d;
    logic          held_q, held_d;
    logic          col_hit;
    logic [1:0]    col_idx;
    logic [3:0]    col_pat;

    sync2 #(.WIDTH(4)) u_col_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .rst_val_i(4'b1111),
        .d_i      (col_n),
        .q_o      (col_s)
    );

    assign {col_hit, col_idx} = col_decode(col_s);
    // Only one column can be latched, so the expected pattern follows from it.
    assign col_pat = ~(4'b0001 << col_q);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        dwell_d  = dwell_q;
        deb_d    = deb_q;
        strobe_d = 1'b0;
        code_d   = code_q;
        held_d   = held_q;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == SCAN_LAST) begin
                    dwell_d = '0;
                    if (col_hit) begin
                        state_d = ST_DEBOUNCE;
                        col_d   = col_idx;
                        deb_d   = '0;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + SW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (col_s != col_pat) begin
                    state_d = ST_SCAN;
                    dwell_d = '0;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d  = ST_RELEASE;
                    deb_d    = '0;
                    strobe_d = 1'b1;
                    code_d   = key_lookup(row_q, col_q);
                    held_d   = 1'b1;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            ST_RELEASE: begin
                if (col_s != 4'b1111) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ST_SCAN;
                    deb_d   = '0;
                    dwell_d = '0;
                    row_d   = row_q + 2'd1;
                    held_d  = 1'b0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
                dwell_d = '0;
                deb_d   = '0;
            end
        endcase
        row_n_d = ~(4'b0001 << row_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_SCAN;
            row_q    <= 2'd0;
            row_n_q  <= 4'b1110;
            col_q    <= 2'd0;
            dwell_q  <= '0;
            deb_q    <= '0;
            strobe_q <= 1'b0;
            code_q   <= 4'h0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            row_n_q  <= row_n_d;
            col_q    <= col_d;
            dwell_q  <= dwell_d;
            deb_q    <= deb_d;
            strobe_q <= strobe_d;
            code_q   <= code_d;
            held_q   <= held_d;
        end
    end

    assign row_n     = row_n_q;
    assign keystrobe = strobe_q;
    assign keycode   = code_q;
    assign key_held  = held_q;

endmodule
